// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocates per dispatch, captures CDB results, answers tag
// queries, retires one entry per cycle and flushes on a mispredicted branch. Option: ROB_CDB_BYPASS_EN.
module reorder_buffer #(
  parameter int ROB_LEN  = 4,
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32,
  parameter int REG_LEN  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                ena_from_dsp,
  input  logic [REG_LEN-1:0]  rd_from_dsp,
  input  logic                is_store_from_dsp,
  input  logic                is_br_from_dsp,
  input  logic                pred_jump_from_dsp,
  input  logic [ADDR_LEN-1:0] pc_from_dsp,
  output logic [ROB_LEN:0]    Q_to_dsp,
  input  logic [ROB_LEN:0]    Q1_from_dsp,
  input  logic [ROB_LEN:0]    Q2_from_dsp,
  output logic                ready1_to_dsp,
  output logic                ready2_to_dsp,
  output logic [DATA_LEN-1:0] V1_to_dsp,
  output logic [DATA_LEN-1:0] V2_to_dsp,
  output logic                full_to_if,
  input  logic                cdb_alu_valid,
  input  logic [ROB_LEN:0]    cdb_alu_Q,
  input  logic [DATA_LEN-1:0] cdb_alu_V,
  input  logic                cdb_alu_jump,
  input  logic [ADDR_LEN-1:0] cdb_alu_target,
  input  logic                cdb_lsb_valid,
  input  logic [ROB_LEN:0]    cdb_lsb_Q,
  input  logic [DATA_LEN-1:0] cdb_lsb_V,
  output logic                commit_flag_to_reg,
  output logic [REG_LEN-1:0]  rd_to_reg,
  output logic [ROB_LEN:0]    Q_to_reg,
  output logic [DATA_LEN-1:0] V_to_reg,
  output logic                commit_store_to_lsb,
  output logic                rollback_flag,
  output logic [ADDR_LEN-1:0] target_pc_to_if
);

  localparam int ROB_SIZE = 2 ** ROB_LEN;
  localparam logic [ROB_LEN:0] TAG_ONE = (ROB_LEN+1)'(1);
  localparam logic [ROB_LEN:0] TAG_MAX = (ROB_LEN+1)'(ROB_SIZE);

  logic [ROB_LEN-1:0]  head;
  logic [ROB_LEN-1:0]  tail;
  logic [ROB_LEN:0]    count;
  logic [ROB_SIZE-1:0] ent_valid;
  logic [ROB_SIZE-1:0] ent_ready;
  logic [ROB_SIZE-1:0] ent_store;
  logic [ROB_SIZE-1:0] ent_br;
  logic [ROB_SIZE-1:0] ent_pred;
  logic [ROB_SIZE-1:0] ent_jump;
  logic [REG_LEN-1:0]  ent_rd     [ROB_SIZE];
  logic [ADDR_LEN-1:0] ent_pc     [ROB_SIZE];
  logic [ADDR_LEN-1:0] ent_target [ROB_SIZE];
  logic [DATA_LEN-1:0] ent_value  [ROB_SIZE];
  logic                store_sent;

  // Tag = index+1, so tag 0 and anything above ROB_SIZE never names an entry.
  function automatic logic tag_ok(input logic [ROB_LEN:0] q);
    return (q != '0) && (q <= TAG_MAX);
  endfunction

  function automatic logic [ROB_LEN-1:0] tag_idx(input logic [ROB_LEN:0] q);
    logic [ROB_LEN:0] t;
    t = q - TAG_ONE;
    return t[ROB_LEN-1:0];
  endfunction

  function automatic logic [DATA_LEN:0] lookup(input logic [ROB_LEN:0] q);
    logic [DATA_LEN:0]  r;
    logic [ROB_LEN-1:0] i;
    r = '0;
    i = tag_idx(q);
    if (tag_ok(q) && ent_valid[i]) begin
      if (ent_ready[i]) r = {1'b1, ent_value[i]};
`ifdef ROB_CDB_BYPASS_EN
      if (cdb_lsb_valid && (cdb_lsb_Q == q)) r = {1'b1, cdb_lsb_V};
      if (cdb_alu_valid && (cdb_alu_Q == q)) r = {1'b1, cdb_alu_V};
`endif
    end
    return r;
  endfunction

  logic [ROB_LEN-1:0] alu_idx;
  logic [ROB_LEN-1:0] lsb_idx;
  logic alu_hit;
  logic lsb_hit;
  logic commit_now;
  logic mispredict;
  logic store_issue;
  logic alloc_ok;
  logic head_writes_reg;

  assign alu_idx = tag_idx(cdb_alu_Q);
  assign lsb_idx = tag_idx(cdb_lsb_Q);
  assign alu_hit = cdb_alu_valid && tag_ok(cdb_alu_Q) && ent_valid[alu_idx];
  assign lsb_hit = cdb_lsb_valid && tag_ok(cdb_lsb_Q) && ent_valid[lsb_idx];

  // A store only retires after it has been released to the LSB and the LSB has reported back.
  assign commit_now = !rollback_flag && ent_valid[head] && ent_ready[head]
                      && (!ent_store[head] || store_sent);
  assign mispredict = commit_now && ent_br[head] && (ent_jump[head] != ent_pred[head]);
  assign store_issue = !rollback_flag && ent_valid[head] && ent_store[head] && !store_sent;
  assign alloc_ok = ena_from_dsp && (count < TAG_MAX) && !rollback_flag;
  assign head_writes_reg = !ent_store[head] && (ent_rd[head] != '0);

  assign Q_to_dsp   = {1'b0, tail} + TAG_ONE;
  assign full_to_if = (count >= (TAG_MAX - TAG_ONE));

  always_comb begin
    {ready1_to_dsp, V1_to_dsp} = lookup(Q1_from_dsp);
    {ready2_to_dsp, V2_to_dsp} = lookup(Q2_from_dsp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head                <= '0;
      tail                <= '0;
      count               <= '0;
      ent_valid           <= '0;
      ent_ready           <= '0;
      store_sent          <= 1'b0;
      commit_flag_to_reg  <= 1'b0;
      rd_to_reg           <= '0;
      Q_to_reg            <= '0;
      V_to_reg            <= '0;
      commit_store_to_lsb <= 1'b0;
      rollback_flag       <= 1'b0;
      target_pc_to_if     <= '0;
    end else if (rdy) begin
      commit_flag_to_reg  <= 1'b0;
      rd_to_reg           <= '0;
      Q_to_reg            <= '0;
      V_to_reg            <= '0;
      commit_store_to_lsb <= 1'b0;
      rollback_flag       <= 1'b0;
      target_pc_to_if     <= '0;
      if (rollback_flag) begin
        // Whole rollback cycle is dead: dispatch and CDB traffic is wrong-path.
        head       <= '0;
        tail       <= '0;
        count      <= '0;
        ent_valid  <= '0;
        ent_ready  <= '0;
        store_sent <= 1'b0;
      end else if (mispredict) begin
        if (head_writes_reg) begin
          commit_flag_to_reg <= 1'b1;
          rd_to_reg          <= ent_rd[head];
          Q_to_reg           <= {1'b0, head} + TAG_ONE;
          V_to_reg           <= ent_value[head];
        end
        rollback_flag   <= 1'b1;
        target_pc_to_if <= ent_jump[head] ? ent_target[head] : ent_pc[head] + ADDR_LEN'(4);
        head       <= '0;
        tail       <= '0;
        count      <= '0;
        ent_valid  <= '0;
        ent_ready  <= '0;
        store_sent <= 1'b0;
      end else begin
        if (alu_hit) begin
          ent_ready[alu_idx]  <= 1'b1;
          ent_value[alu_idx]  <= cdb_alu_V;
          ent_jump[alu_idx]   <= cdb_alu_jump;
          ent_target[alu_idx] <= cdb_alu_target;
        end
        if (lsb_hit) begin
          ent_ready[lsb_idx] <= 1'b1;
          ent_value[lsb_idx] <= cdb_lsb_V;
        end
        if (commit_now) begin
          if (head_writes_reg) begin
            commit_flag_to_reg <= 1'b1;
            rd_to_reg          <= ent_rd[head];
            Q_to_reg           <= {1'b0, head} + TAG_ONE;
            V_to_reg           <= ent_value[head];
          end
          ent_valid[head] <= 1'b0;
          head            <= head + ROB_LEN'(1);
          store_sent      <= 1'b0;
        end else if (store_issue) begin
          commit_store_to_lsb <= 1'b1;
          store_sent          <= 1'b1;
        end
        if (alloc_ok) begin
          ent_valid[tail] <= 1'b1;
          ent_ready[tail] <= 1'b0;
          ent_store[tail] <= is_store_from_dsp;
          ent_br[tail]    <= is_br_from_dsp;
          ent_pred[tail]  <= pred_jump_from_dsp;
          ent_jump[tail]  <= 1'b0;
          ent_rd[tail]    <= rd_from_dsp;
          ent_pc[tail]    <= pc_from_dsp;
          tail            <= tail + ROB_LEN'(1);
        end
        if (alloc_ok && !commit_now) count <= count + TAG_ONE;
        else if (!alloc_ok && commit_now) count <= count - TAG_ONE;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios then random traffic, all checked against a
// queue-based model of the in-order retirement rules.
module tb_reorder_buffer;

  localparam int SZ = 16;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        ena_from_dsp, is_store_from_dsp, is_br_from_dsp, pred_jump_from_dsp;
  logic [4:0]  rd_from_dsp;
  logic [31:0] pc_from_dsp;
  logic [4:0]  Q_to_dsp, Q1_from_dsp, Q2_from_dsp;
  logic        ready1_to_dsp, ready2_to_dsp, full_to_if;
  logic [31:0] V1_to_dsp, V2_to_dsp;
  logic        cdb_alu_valid, cdb_alu_jump, cdb_lsb_valid;
  logic [4:0]  cdb_alu_Q, cdb_lsb_Q;
  logic [31:0] cdb_alu_V, cdb_alu_target, cdb_lsb_V;
  logic        commit_flag_to_reg, commit_store_to_lsb, rollback_flag;
  logic [4:0]  rd_to_reg, Q_to_reg;
  logic [31:0] V_to_reg, target_pc_to_if;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ena_from_dsp(ena_from_dsp), .rd_from_dsp(rd_from_dsp),
    .is_store_from_dsp(is_store_from_dsp), .is_br_from_dsp(is_br_from_dsp),
    .pred_jump_from_dsp(pred_jump_from_dsp), .pc_from_dsp(pc_from_dsp),
    .Q_to_dsp(Q_to_dsp), .Q1_from_dsp(Q1_from_dsp), .Q2_from_dsp(Q2_from_dsp),
    .ready1_to_dsp(ready1_to_dsp), .ready2_to_dsp(ready2_to_dsp),
    .V1_to_dsp(V1_to_dsp), .V2_to_dsp(V2_to_dsp), .full_to_if(full_to_if),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_Q(cdb_alu_Q), .cdb_alu_V(cdb_alu_V),
    .cdb_alu_jump(cdb_alu_jump), .cdb_alu_target(cdb_alu_target),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_Q(cdb_lsb_Q), .cdb_lsb_V(cdb_lsb_V),
    .commit_flag_to_reg(commit_flag_to_reg), .rd_to_reg(rd_to_reg), .Q_to_reg(Q_to_reg),
    .V_to_reg(V_to_reg), .commit_store_to_lsb(commit_store_to_lsb),
    .rollback_flag(rollback_flag), .target_pc_to_if(target_pc_to_if)
  );

  typedef struct {
    int          tag;
    logic [4:0]  rd;
    bit          st, br, pj, done, j;
    logic [31:0] pc, v, tgt;
  } ent_t;

  ent_t        mq[$];
  int          next_tag;
  bit          sent, rb;
  logic        e_cf, e_st, e_rb;
  logic [4:0]  e_rd, e_q;
  logic [31:0] e_v, e_tgt;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic int find(input int tag);
    foreach (mq[i]) if (mq[i].tag == tag) return i;
    return -1;
  endfunction

  function automatic logic [32:0] qry(input logic [4:0] t);
    int k;
    logic [32:0] r;
    k = find(int'(t));
    r = '0;
    if (k >= 0 && mq[k].done) r = {1'b1, mq[k].v};
`ifdef ROB_CDB_BYPASS_EN
    if (k >= 0 && cdb_lsb_valid && cdb_lsb_Q == t) r = {1'b1, cdb_lsb_V};
    if (k >= 0 && cdb_alu_valid && cdb_alu_Q == t) r = {1'b1, cdb_alu_V};
`endif
    return r;
  endfunction

  task automatic clear_out();
    e_cf = 0; e_st = 0; e_rb = 0; e_rd = 0; e_q = 0; e_v = 0; e_tgt = 0;
  endtask

  // Reference behaviour at a clock edge, from the inputs currently driven.
  task automatic model_edge();
    int n, k;
    bit com, mis;
    ent_t h, t;
    if (rst) begin
      mq.delete(); next_tag = 1; sent = 0; rb = 0; clear_out(); return;
    end
    if (!rdy) return;
    clear_out();
    if (rb) begin rb = 0; mq.delete(); return; end
    n = mq.size(); com = 0; mis = 0;
    if (n > 0 && mq[0].done && (!mq[0].st || sent)) begin
      com = 1; h = mq[0]; mis = h.br && (h.j != h.pj);
    end else if (n > 0 && mq[0].st && !sent) begin
      e_st = 1; sent = 1;
    end
    if (mis) begin
      if (h.rd != 0) begin e_cf = 1; e_rd = h.rd; e_q = 5'(h.tag); e_v = h.v; end
      e_rb = 1; e_tgt = h.j ? h.tgt : h.pc + 32'd4;
      mq.delete(); next_tag = 1; sent = 0; rb = 1;
      return;
    end
    if (cdb_alu_valid) begin
      k = find(int'(cdb_alu_Q));
      if (k >= 0) begin
        t = mq[k]; t.done = 1; t.v = cdb_alu_V; t.j = cdb_alu_jump; t.tgt = cdb_alu_target; mq[k] = t;
      end
    end
    if (cdb_lsb_valid) begin
      k = find(int'(cdb_lsb_Q));
      if (k >= 0) begin t = mq[k]; t.done = 1; t.v = cdb_lsb_V; mq[k] = t; end
    end
    if (com) begin
      if (!h.st && h.rd != 0) begin e_cf = 1; e_rd = h.rd; e_q = 5'(h.tag); e_v = h.v; end
      void'(mq.pop_front()); sent = 0;
    end
    if (ena_from_dsp && n < SZ) begin
      t = '{tag: next_tag, rd: rd_from_dsp, st: is_store_from_dsp, br: is_br_from_dsp,
            pj: pred_jump_from_dsp, done: 0, j: 0, pc: pc_from_dsp, v: 0, tgt: 0};
      mq.push_back(t);
      next_tag = next_tag % SZ + 1;
    end
  endtask

  task automatic applyStimulus();
    logic [32:0] r1, r2;
    #1;
    r1 = qry(Q1_from_dsp); r2 = qry(Q2_from_dsp);
    chk("q_to_dsp", Q_to_dsp, next_tag);
    chk("full", full_to_if, mq.size() >= SZ - 1);
    chk("ready1", ready1_to_dsp, r1[32]);
    chk("v1", V1_to_dsp, r1[31:0]);
    chk("ready2", ready2_to_dsp, r2[32]);
    chk("v2", V2_to_dsp, r2[31:0]);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic checkOutput();
    chk("commit_flag", commit_flag_to_reg, e_cf);
    chk("rd_to_reg", rd_to_reg, e_rd);
    chk("q_to_reg", Q_to_reg, e_q);
    chk("v_to_reg", V_to_reg, e_v);
    chk("commit_store", commit_store_to_lsb, e_st);
    chk("rollback", rollback_flag, e_rb);
    chk("target_pc", target_pc_to_if, e_tgt);
  endtask

  task automatic step();
    applyStimulus();
    checkOutput();
  endtask

  task automatic idle();
    ena_from_dsp = 0; rd_from_dsp = 0; is_store_from_dsp = 0; is_br_from_dsp = 0;
    pred_jump_from_dsp = 0; pc_from_dsp = 0; Q1_from_dsp = 0; Q2_from_dsp = 0;
    cdb_alu_valid = 0; cdb_alu_Q = 0; cdb_alu_V = 0; cdb_alu_jump = 0; cdb_alu_target = 0;
    cdb_lsb_valid = 0; cdb_lsb_Q = 0; cdb_lsb_V = 0;
  endtask

  task automatic alloc(input logic [4:0] rd, input bit st, input bit br, input bit pj,
                       input logic [31:0] pc);
    ena_from_dsp = 1; rd_from_dsp = rd; is_store_from_dsp = st; is_br_from_dsp = br;
    pred_jump_from_dsp = pj; pc_from_dsp = pc;
  endtask

  task automatic alu(input int tag, input logic [31:0] v, input bit j, input logic [31:0] tgt);
    cdb_alu_valid = 1; cdb_alu_Q = 5'(tag); cdb_alu_V = v; cdb_alu_jump = j; cdb_alu_target = tgt;
  endtask

  task automatic lsb(input int tag, input logic [31:0] v);
    cdb_lsb_valid = 1; cdb_lsb_Q = 5'(tag); cdb_lsb_V = v;
  endtask

  initial begin
    int t1, t2;
    int pend[$];
    next_tag = 1; sent = 0; rb = 0; clear_out();
    idle(); rst = 1; rdy = 1;
    step(); step();
    chk("rst_q_to_dsp", Q_to_dsp, 1);
    chk("rst_full", full_to_if, 0);
    rst = 0;

    $display("[TB] single alloc and commit");
    alloc(5, 0, 0, 0, 32'h100); step();
    idle(); alu(1, 32'h2A, 0, 0); step();
    idle(); step();
    chk("t1_flag", commit_flag_to_reg, 1);
    chk("t1_rd", rd_to_reg, 5);
    chk("t1_q", Q_to_reg, 1);
    chk("t1_v", V_to_reg, 32'h2A);
    step();

    $display("[TB] fill and wrap");
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 17; i++) begin
      idle(); alloc(5'(i + 1), 0, 0, 0, 32'(i * 4)); step();
      if (i == 14) chk("t2_full15", full_to_if, 1);
    end
    chk("t2_wrap_tag", Q_to_dsp, 1);
    idle(); rst = 1; step(); rst = 0;

    $display("[TB] out-of-order completion");
    for (int i = 0; i < 3; i++) begin idle(); alloc(5'(i + 10), 0, 0, 0, 0); step(); end
    idle(); alu(3, 33, 0, 0); step();
    idle(); alu(2, 22, 0, 0); Q1_from_dsp = 3; step();
    idle(); lsb(1, 11); step();
    for (int i = 0; i < 5; i++) begin idle(); step(); end

    $display("[TB] mispredict");
    t1 = next_tag;
    idle(); alloc(0, 0, 1, 0, 32'h200); step();
    idle(); alloc(7, 0, 0, 0, 32'h204); step();
    idle(); alu(t1, 0, 1, 32'h1000); step();
    idle(); step();
    chk("t4_rollback", rollback_flag, 1);
    chk("t4_target", target_pc_to_if, 32'h1000);
    idle(); alloc(9, 0, 0, 0, 0); step();
    chk("t4_q_after", Q_to_dsp, 1);
    chk("t4_rb_drop", rollback_flag, 0);

    $display("[TB] query against same-cycle broadcast");
    idle(); alloc(1, 0, 0, 0, 0); step();
    t2 = next_tag;
    idle(); alloc(2, 0, 0, 0, 0); step();
    idle(); lsb(t2, 7); Q1_from_dsp = 5'(t2); step();
    idle(); Q1_from_dsp = 5'(t2); step();
    chk("t5_ready_next", ready1_to_dsp, 1);
    chk("t5_v_next", V1_to_dsp, 7);

    $display("[TB] store and rdy hold");
    idle(); rst = 1; step(); rst = 0;
    idle(); alloc(3, 1, 0, 0, 0); step();
    idle(); step();
    idle(); lsb(1, 0); step();
    idle(); rdy = 0; alloc(4, 0, 0, 0, 0); step();
    rdy = 1; idle(); step();

    $display("[TB] reset overrides commit");
    t1 = next_tag;
    idle(); alloc(6, 0, 0, 0, 0); step();
    idle(); alu(t1, 32'h55, 0, 0); step();
    idle(); rst = 1; step();
    chk("t6_no_commit", commit_flag_to_reg, 0);
    rst = 0;

    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) begin
      idle();
      rst = ($urandom_range(0, 249) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) != 0) begin
        is_store_from_dsp = ($urandom_range(0, 5) == 0);
        alloc($urandom, is_store_from_dsp, !is_store_from_dsp && ($urandom_range(0, 4) == 0),
              $urandom, $urandom & 32'hFFFF_FFFC);
      end
      pend.delete();
      foreach (mq[i]) if (!mq[i].done) pend.push_back(mq[i].tag);
      if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
        t1 = pend[$urandom_range(0, pend.size() - 1)];
        alu(t1, $urandom, $urandom, $urandom);
      end else if ($urandom_range(0, 4) == 0) begin
        alu($urandom_range(0, 31), $urandom, $urandom, $urandom);
      end
      if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
        t2 = pend[$urandom_range(0, pend.size() - 1)];
        if (!(cdb_alu_valid && cdb_alu_Q == 5'(t2)) && !mq[find(t2)].br) lsb(t2, $urandom);
      end
      Q1_from_dsp = cdb_lsb_valid && $urandom_range(0, 1) ? cdb_lsb_Q : 5'($urandom_range(0, 16));
      Q2_from_dsp = cdb_alu_valid && $urandom_range(0, 1) ? cdb_alu_Q : 5'($urandom_range(0, 16));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
